// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_JUMP = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_PC4  = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b011;
  localparam logic [2:0] MOP_HU = 3'b100;

  localparam logic       SRC_A_RS1  = 1'b0;
  localparam logic       SRC_A_PC   = 1'b1;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM    = 2'b10;
  localparam logic [1:0] TC_DMEM    = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  // Instruction class steers the FSM path after DECODE.
  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_LOAD, CLS_STORE
  } cls_e;

  typedef struct packed {
    logic       alu_a_src;
    logic [1:0] alu_b_src;
    logic [3:0] alu_ctrl;
    logic [2:0] branch;
    logic       mem_to_reg;
    logic [2:0] mem_op;
    logic       reg_wr;
    cls_e       cls;
  } ctrl_t;

  // Reset / NOP control word: everything idle, next PC = PC+4.
  localparam ctrl_t CTRL_NOP = '{
    alu_a_src:  SRC_A_RS1,
    alu_b_src:  SRC_B_RS2,
    alu_ctrl:   ALU_ADD,
    branch:     BR_PC4,
    mem_to_reg: 1'b0,
    mem_op:     MOP_B,
    reg_wr:     1'b0,
    cls:        CLS_ALU
  };

  // ALU operation from funct3; alt selects SUB/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decode: IR to control word plus illegal flag.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // Decode by opcode; an illegal encoding collapses to the NOP word.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.alu_ctrl   = alu_op(funct3, funct7[5]);
        if (!((funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_b_src  = SRC_B_IMM;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.alu_ctrl   = alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        if ((funct3 == 3'b001) && (funct7 != 7'b0000000))
          illegal = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
          illegal = 1'b1;
      end
      OPC_LUI: begin
        // datapath presents x0 on the A port for U-type
        ctrl.alu_b_src  = SRC_B_IMM;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_a_src  = SRC_A_PC;
        ctrl.alu_b_src  = SRC_B_IMM;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl.alu_a_src  = SRC_A_PC;
        ctrl.alu_b_src  = SRC_B_FOUR;
        ctrl.branch     = BR_JUMP;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.cls        = CLS_JUMP;
      end
      OPC_BRANCH: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.cls      = CLS_BRANCH;
        case (funct3)
          3'b000:  ctrl.branch = BR_BEQ;
          3'b001:  ctrl.branch = BR_BNE;
          3'b100:  ctrl.branch = BR_BLT;
          3'b101:  ctrl.branch = BR_BGE;
          3'b110:  ctrl.branch = BR_BLTU;
          3'b111:  ctrl.branch = BR_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.alu_b_src = SRC_B_IMM;
        ctrl.reg_wr    = 1'b1;
        ctrl.cls       = CLS_LOAD;
        case (funct3)
          3'b000:  ctrl.mem_op = MOP_B;
          3'b001:  ctrl.mem_op = MOP_H;
          3'b010:  ctrl.mem_op = MOP_W;
          3'b100:  ctrl.mem_op = MOP_BU;
          3'b101:  ctrl.mem_op = MOP_HU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.alu_b_src = SRC_B_IMM;
        ctrl.cls       = CLS_STORE;
        ctrl.mem_op    = funct3;
        if (funct3 > 3'b010)
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal)
      ctrl = CTRL_NOP;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with memory watchdog and retire counter.
module mc_control_unit
  import rv32i_pkg::*;
#(
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned TIMEOUT         = 255,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [31:0]      instr,
  output logic             dmem_req,
  input  logic             dmem_valid,
  output logic             ir_we,
  output logic             pc_we,
  output logic             RegWr,
  output logic             MemWr,
  output logic             ALUAsrc,
  output logic [1:0]       ALUBsrc,
  output logic [3:0]       ALUctrl,
  output logic [2:0]       Branch,
  output logic             memToReg,
  output logic [2:0]       MemOp,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);

  state_e         state, next_state;
  logic [31:0]    ir, ir_d;
  ctrl_t          cw, cw_d, dec;
  logic           dec_illegal;
  logic [TW-1:0]  cnt, cnt_d;
  logic           cnt_inc, wd_expired;
  logic           imem_req_d, dmem_req_d, ir_we_d, pc_we_d, reg_wr_d, mem_wr_d, retire_d;
  logic           trap_d;
  logic [1:0]     cause_d;

  rv32i_decoder u_decoder (
    .ir      (ir),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

  assign ALUAsrc    = cw.alu_a_src;
  assign ALUBsrc    = cw.alu_b_src;
  assign ALUctrl    = cw.alu_ctrl;
  assign Branch     = cw.branch;
  assign memToReg   = cw.mem_to_reg;
  assign MemOp      = cw.mem_op;
  assign wd_expired = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT));

  // Next state, next control word and next registered strobes.
  always_comb begin
    next_state = state;
    ir_d       = ir;
    cw_d       = cw;
    cnt_inc    = 1'b0;
    ir_we_d    = 1'b0;
    pc_we_d    = 1'b0;
    reg_wr_d   = 1'b0;
    retire_d   = 1'b0;
    trap_d     = trap;
    cause_d    = trap_cause;

    case (state)
      S_FETCH: begin
        if (imem_req && imem_valid) begin
          ir_d       = instr;
          ir_we_d    = 1'b1;
          next_state = S_DECODE;
        end else if (imem_req) begin
          if (wd_expired) begin
            trap_d     = 1'b1;
            cause_d    = TC_IMEM;
            next_state = S_TRAP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        cw_d = dec;
        if (dec_illegal && TRAP_ON_ILLEGAL) begin
          trap_d     = 1'b1;
          cause_d    = TC_ILLEGAL;
          next_state = S_TRAP;
        end else begin
          next_state = S_EXEC;
          if ((dec.cls == CLS_BRANCH) || (dec.cls == CLS_JUMP))
            pc_we_d = 1'b1;
          if (dec.cls == CLS_BRANCH)
            retire_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (cw.cls)
          CLS_BRANCH:           next_state = S_FETCH;
          CLS_LOAD, CLS_STORE:  next_state = S_MEM;
          default:              next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_req && dmem_valid) begin
          if (cw.cls == CLS_LOAD) begin
            next_state = S_WB;
          end else begin
            pc_we_d    = 1'b1;
            retire_d   = 1'b1;
            next_state = S_FETCH;
          end
        end else if (dmem_req) begin
          if (wd_expired) begin
            trap_d     = 1'b1;
            cause_d    = TC_DMEM;
            next_state = S_TRAP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_WB:    next_state = S_FETCH;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase

    // Requests and MemWr follow the state being entered; WB strobes fire on entry.
    imem_req_d = (next_state == S_FETCH);
    dmem_req_d = (next_state == S_MEM);
    mem_wr_d   = (next_state == S_MEM) && (cw_d.cls == CLS_STORE);
    if (next_state == S_WB) begin
      reg_wr_d = cw_d.reg_wr;
      pc_we_d  = (cw_d.cls != CLS_JUMP);
      retire_d = 1'b1;
    end

    if (next_state != state)
      cnt_d = '0;
    else if (cnt_inc)
      cnt_d = cnt + TW'(1);
    else
      cnt_d = cnt;
  end

  // State, control word, strobes, watchdog and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      ir         <= '0;
      cw         <= CTRL_NOP;
      cnt        <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      ir_we      <= 1'b0;
      pc_we      <= 1'b0;
      RegWr      <= 1'b0;
      MemWr      <= 1'b0;
      retire     <= 1'b0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      state      <= next_state;
      ir         <= ir_d;
      cw         <= cw_d;
      cnt        <= cnt_d;
      imem_req   <= imem_req_d;
      dmem_req   <= dmem_req_d;
      ir_we      <= ir_we_d;
      pc_we      <= pc_we_d;
      RegWr      <= reg_wr_d;
      MemWr      <= mem_wr_d;
      retire     <= retire_d;
      instret    <= instret + CNT_W'(retire_d);
      trap       <= trap_d;
      trap_cause <= cause_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: default instance plus a NOP-mode, TIMEOUT=4 instance.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // default instance
  logic        rst, imem_valid, dmem_valid;
  logic [31:0] instr;
  logic        imem_req, dmem_req, ir_we, pc_we, reg_wr, mem_wr, alu_a, mem_to_reg, retire, trap;
  logic [1:0]  alu_b, trap_cause;
  logic [3:0]  alu_ctrl;
  logic [2:0]  branch, mem_op;
  logic [31:0] instret;

  // NOP-mode / short-timeout instance
  logic        rst2, imem_valid2, dmem_valid2;
  logic [31:0] instr2;
  logic        imem_req2, dmem_req2, ir_we2, pc_we2, reg_wr2, mem_wr2, alu_a2, mem_to_reg2, retire2, trap2;
  logic [1:0]  alu_b2, trap_cause2;
  logic [3:0]  alu_ctrl2;
  logic [2:0]  branch2, mem_op2;
  logic [31:0] instret2;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_valid(imem_valid), .instr(instr),
    .dmem_req(dmem_req), .dmem_valid(dmem_valid), .ir_we(ir_we), .pc_we(pc_we),
    .RegWr(reg_wr), .MemWr(mem_wr), .ALUAsrc(alu_a), .ALUBsrc(alu_b), .ALUctrl(alu_ctrl),
    .Branch(branch), .memToReg(mem_to_reg), .MemOp(mem_op), .retire(retire),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  mc_control_unit #(.TRAP_ON_ILLEGAL(1'b0), .TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_valid(imem_valid2), .instr(instr2),
    .dmem_req(dmem_req2), .dmem_valid(dmem_valid2), .ir_we(ir_we2), .pc_we(pc_we2),
    .RegWr(reg_wr2), .MemWr(mem_wr2), .ALUAsrc(alu_a2), .ALUBsrc(alu_b2), .ALUctrl(alu_ctrl2),
    .Branch(branch2), .memToReg(mem_to_reg2), .MemOp(mem_op2), .retire(retire2),
    .instret(instret2), .trap(trap2), .trap_cause(trap_cause2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction with zero-wait imem; returns in DECODE.
  task automatic fetch(input logic [31:0] w);
    instr = w;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
  endtask

  task automatic fetch2(input logic [31:0] w);
    instr2 = w;
    imem_valid2 = 1'b1;
    tick();
    imem_valid2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0; instr = '0;
    rst2 = 1'b1; imem_valid2 = 1'b0; dmem_valid2 = 1'b0; instr2 = '0;
    tick(); tick();

    // reset values
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_branch",   32'(branch),   32'b110);
    check("rst_instret",  instret,       32'd0);
    check("rst_trap",     32'(trap),     32'd0);
    check("rst_retire",   32'(retire),   32'd0);

    rst = 1'b0;
    tick();
    check("req_after_rst", 32'(imem_req), 32'd1);

    // addi x1,x0,5 : cycles FETCH, DECODE, EXEC, WB
    fetch(32'h00500093);
    check("addi_ir_we",     32'(ir_we),    32'd1);
    check("addi_req_drop",  32'(imem_req), 32'd0);
    tick();
    check("addi_alub",      32'(alu_b),    32'b01);
    check("addi_aluctrl",   32'(alu_ctrl), 32'b0000);
    check("addi_no_regwr3", 32'(reg_wr),   32'd0);
    tick();
    check("addi_regwr4",    32'(reg_wr),   32'd1);
    check("addi_pc_we",     32'(pc_we),    32'd1);
    check("addi_retire",    32'(retire),   32'd1);
    check("addi_instret",   instret,       32'd1);
    tick();
    check("addi_next_req",  32'(imem_req), 32'd1);

    // sub x3,x1,x2 then sltiu
    fetch(32'h402081B3);
    tick();
    check("sub_aluctrl",    32'(alu_ctrl), 32'b1011);
    check("sub_alub",       32'(alu_b),    32'b00);
    tick();
    check("sub_regwr",      32'(reg_wr),   32'd1);
    tick();
    fetch(32'h0010B093);
    tick();
    check("sltiu_aluctrl",  32'(alu_ctrl), 32'b0010);
    check("sltiu_alub",     32'(alu_b),    32'b01);
    tick(); tick();

    // lw x5,8(x2) with dmem_valid three cycles late
    fetch(32'h00812283);
    tick();
    check("lw_memop",       32'(mem_op),     32'b010);
    check("lw_memtoreg",    32'(mem_to_reg), 32'd0);
    tick();
    check("lw_dreq_c4",     32'(dmem_req),   32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_dreq_held", 32'(dmem_req),   32'd1);
      check("lw_no_regwr",  32'(reg_wr),     32'd0);
    end
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    check("lw_regwr_c8",    32'(reg_wr),     32'd1);
    check("lw_dreq_drop",   32'(dmem_req),   32'd0);
    check("lw_instret",     instret,         32'd4);
    tick();

    // sw x1,8(x3) zero-wait
    fetch(32'h0011A423);
    tick();
    check("sw_memop",       32'(mem_op),   32'b010);
    tick();
    check("sw_memwr",       32'(mem_wr),   32'd1);
    check("sw_dreq",        32'(dmem_req), 32'd1);
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    check("sw_pc_we",       32'(pc_we),    32'd1);
    check("sw_retire",      32'(retire),   32'd1);
    check("sw_memwr_drop",  32'(mem_wr),   32'd0);
    check("sw_no_regwr",    32'(reg_wr),   32'd0);
    check("sw_instret",     instret,       32'd5);
    check("sw_next_req",    32'(imem_req), 32'd1);

    // bltu x1,x2,8 : 3 cycles, retire in EXEC
    fetch(32'h0020E463);
    tick();
    check("bltu_branch",    32'(branch),   32'b101);
    check("bltu_pc_we",     32'(pc_we),    32'd1);
    check("bltu_retire",    32'(retire),   32'd1);
    check("bltu_no_regwr",  32'(reg_wr),   32'd0);
    check("bltu_instret",   instret,       32'd6);
    tick();
    check("bltu_next_req",  32'(imem_req), 32'd1);
    check("bltu_no_regwr4", 32'(reg_wr),   32'd0);

    // stray dmem_valid during FETCH is ignored
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    check("stray_req",      32'(imem_req), 32'd1);
    check("stray_dreq",     32'(dmem_req), 32'd0);
    check("stray_retire",   32'(retire),   32'd0);

    // jal x1,0
    fetch(32'h000000EF);
    tick();
    check("jal_branch",     32'(branch),   32'b100);
    check("jal_alua",       32'(alu_a),    32'd1);
    check("jal_alub",       32'(alu_b),    32'b10);
    check("jal_pc_we",      32'(pc_we),    32'd1);
    check("jal_retire3",    32'(retire),   32'd0);
    tick();
    check("jal_regwr",      32'(reg_wr),   32'd1);
    check("jal_no_pc_we",   32'(pc_we),    32'd0);
    check("jal_retire",     32'(retire),   32'd1);
    check("jal_instret",    instret,       32'd7);
    tick();

    // illegal instruction traps
    fetch(32'hFFFFFFFF);
    tick();
    check("ill_trap",       32'(trap),       32'd1);
    check("ill_cause",      32'(trap_cause), 32'b01);
    check("ill_req",        32'(imem_req),   32'd0);
    tick(); tick(); tick();
    check("ill_req_held",   32'(imem_req),   32'd0);
    check("ill_retire",     32'(retire),     32'd0);
    check("ill_instret",    instret,         32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ill_rst_trap",   32'(trap),       32'd0);
    check("ill_rst_cause",  32'(trap_cause), 32'd0);
    check("ill_rst_inst",   instret,         32'd0);
    tick();
    check("ill_rst_req",    32'(imem_req),   32'd1);

    // second instance: illegal retires as NOP
    rst2 = 1'b0;
    tick();
    check("n_req",          32'(imem_req2), 32'd1);
    fetch2(32'hFFFFFFFF);
    tick();
    check("nop_no_trap",    32'(trap2),     32'd0);
    tick();
    check("nop_no_regwr",   32'(reg_wr2),   32'd0);
    check("nop_pc_we",      32'(pc_we2),    32'd1);
    check("nop_retire",     32'(retire2),   32'd1);
    check("nop_instret",    instret2,       32'd1);
    tick();
    check("nop_next_req",   32'(imem_req2), 32'd1);

    // imem valid exactly when the counter reaches TIMEOUT is accepted
    repeat (4) tick();
    check("edge_req",       32'(imem_req2), 32'd1);
    check("edge_no_trap",   32'(trap2),     32'd0);
    fetch2(32'h00500093);
    check("edge_ir_we",     32'(ir_we2),    32'd1);
    check("edge_trap",      32'(trap2),     32'd0);
    tick(); tick();
    check("edge_regwr",     32'(reg_wr2),   32'd1);
    check("edge_instret",   instret2,       32'd2);
    tick();

    // dmem timeout
    fetch2(32'h00812283);
    tick(); tick();
    check("dto_dreq",       32'(dmem_req2), 32'd1);
    repeat (4) tick();
    check("dto_dreq_held",  32'(dmem_req2), 32'd1);
    check("dto_no_trap",    32'(trap2),     32'd0);
    tick();
    check("dto_trap",       32'(trap2),       32'd1);
    check("dto_cause",      32'(trap_cause2), 32'b11);
    check("dto_dreq_drop",  32'(dmem_req2),   32'd0);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("dto_rst_trap",   32'(trap2),       32'd0);
    tick();
    check("dto_rst_req",    32'(imem_req2),   32'd1);

    // imem timeout, then reset from TRAP
    repeat (4) tick();
    check("ito_no_trap",    32'(trap2),       32'd0);
    check("ito_req_held",   32'(imem_req2),   32'd1);
    tick();
    check("ito_trap",       32'(trap2),       32'd1);
    check("ito_cause",      32'(trap_cause2), 32'b10);
    check("ito_req_drop",   32'(imem_req2),   32'd0);
    tick(); tick();
    check("ito_req_stays",  32'(imem_req2),   32'd0);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("ito_rst_trap",   32'(trap2),       32'd0);
    check("ito_rst_cause",  32'(trap_cause2), 32'd0);
    check("ito_rst_inst",   instret2,         32'd0);
    tick();
    check("ito_rst_req",    32'(imem_req2),   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle, handshake-driven control unit for the RV32I core. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK around a single shared ALU. It latches a registered control word per instruction and drives request/valid handshakes to the instruction and data memories. It adds illegal-instruction trapping, a memory-timeout watchdog and a retired-instruction counter, and it corrects SLTIU, B-type and load decode.

## Interface
- `TRAP_ON_ILLEGAL`, default 1: 1 sends illegal encodings to TRAP; 0 retires them as NOPs.
- `TIMEOUT`, default 255: maximum wait cycles on any memory handshake; 0 disables the watchdog.
- `CNT_W`, default 32: width of `instret`.
- `clk` input 1: the single clock.
- `rst` input 1: reset. Synchronous and active-high.
- `imem_req` output 1: instruction fetch request.
- `imem_valid` input 1: `instr` is valid in this cycle.
- `instr` input 32: fetched instruction.
- `dmem_req` output 1: data access request.
- `dmem_valid` input 1: data access complete (read data valid, or write accepted).
- `ir_we`, `pc_we`, `RegWr`, `MemWr` outputs, 1 each: one-cycle strobes.
- `ALUAsrc` output 1: 0 selects rs1, 1 selects PC.
- `ALUBsrc` output 2: 00 rs2, 01 imm, 10 constant 4.
- `ALUctrl` output 4: ALU operation.
- `Branch` output 3: next-PC select.
- `memToReg` output 1: 0 selects memory data, 1 selects ALU result.
- `MemOp` output 3: access size and sign.
- `retire` output 1: one-cycle pulse per completed instruction.
- `instret` output CNT_W: count of retired instructions.
- `trap` output 1: sticky. Set on an illegal instruction or a timeout.
- `trap_cause` output 2: 01 illegal instruction, 10 imem timeout, 11 dmem timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: `imem_req` is high until `imem_valid`. On `imem_valid`, pulse `ir_we` and go to DECODE.
- DECODE: register the control word from the IR. Go to TRAP if the encoding is illegal and TRAP_ON_ILLEGAL=1; otherwise go to EXEC.
- EXEC:
  - Branch or JAL/JALR: pulse `pc_we`.
  - JAL/JALR also go to WB. Branch pulses `retire` and goes to FETCH.
  - Loads and stores go to MEM.
  - ALU, LUI and AUIPC go to WB.
- MEM: `dmem_req` is high until `dmem_valid`. `MemWr` is high for the whole state on stores.
  - Load with `dmem_valid`: go to WB.
  - Store with `dmem_valid`: pulse `pc_we` and `retire`, then go to FETCH.
- WB: pulse `RegWr`. Pulse `pc_we` unless the instruction is a jump. Pulse `retire`. Go to FETCH.
- TRAP: all strobes and requests are low. The state is held until `rst`.
- ALUctrl codes: ADD 0000, SLT 0001, SLTU 0010, XOR 0011, OR 0100, AND 0111, SLL 1000, SRL 1001, SRA 1010, SUB 1011. SLTIU uses 0010.
- Branch codes: BEQ 000, BNE 001, BLT 010, BGE 011, jump 100, BLTU 101, PC+4 110, BGEU 111.
- The B-type opcode is 1100011. Branches use SUB on rs1/rs2.
- JALR: ALUAsrc=1, ALUBsrc=10 for the link value; jump target selected through `Branch`=100.
- MemOp codes: LB/SB 000, LH/SH 001, LW/SW 010, LBU 011, LHU 100. Loads drive RegWr=1 in WB.
- Illegal encodings:
  - unknown opcode;
  - R-type funct7 other than 0000000, or other than 0100000 for funct3 000/101;
  - shift-immediate with a bad funct7;
  - load funct3 011, 110 or 111;
  - store funct3 above 010;
  - B-type funct3 010 or 011.
- NOP mode (TRAP_ON_ILLEGAL=0): the illegal instruction goes EXEC → WB with RegWr suppressed, and retires.
- Watchdog: a counter clears on entry to FETCH or MEM and increments while waiting. When it reaches TIMEOUT with no valid, set `trap` and `trap_cause`, then go to TRAP.
- `instret` wraps at 2^CNT_W.

## Timing
- Reset: the state is FETCH; all strobes, `imem_req`, `dmem_req`, `trap`, `trap_cause`, `instret` and `retire` are 0. The control word resets to 0, except `Branch`=110.
- `imem_req` first goes high in the cycle after `rst` falls.
- With zero-wait memory (valid in the same cycle as req):
  - branch: 3 cycles;
  - ALU, LUI, AUIPC, jump: 4 cycles;
  - store: 4 cycles;
  - load: 5 cycles.
- The control word is stable from the cycle after DECODE through the end of the instruction.
- Every requirement above holds for any number of wait cycles below TIMEOUT.
- A valid arriving in the same cycle the counter reaches TIMEOUT is accepted; the timeout does not fire.
- `rst` in any state, including TRAP or mid-handshake, aborts the operation: the next cycle is FETCH, with requests dropped and counters cleared.
- A valid arriving outside its request state is ignored.

## Structure
- Shared package `rv32i_pkg` holds:
  - the opcode constants;
  - the ALUctrl, Branch and MemOp encodings;
  - the state enum and the trap_cause codes.
- One sub-module, `rv32i_decoder`: a combinational decode from IR to control word plus the illegal flag. The FSM, watchdog and counter live in the top module.

## Test plan
- addi x1,x0,5 (0x00500093), zero-wait: ALUBsrc=01, ALUctrl=0000; RegWr in cycle 4; instret=1.
- sub x3,x1,x2 (0x402081B3): ALUctrl=1011; then sltiu (0x0010B093): ALUctrl=0010.
- lw x5,8(x2) (0x00812283) with dmem_valid delayed 3 cycles: MemOp=010, memToReg=0, `dmem_req` held 4 cycles, RegWr 8 cycles after FETCH entry.
- bltu x1,x2,8 (0x0020E463): Branch=101, `pc_we` and `retire` in cycle 3, RegWr never asserted.
- 0xFFFFFFFF with TRAP_ON_ILLEGAL=1: trap=1, trap_cause=01, no further `imem_req`. With TRAP_ON_ILLEGAL=0: retires as NOP.
- TIMEOUT=4 with imem_valid never asserted: trap_cause=10 after 4 wait cycles. Then `rst` pulse: FETCH next cycle, trap=0, instret=0.
